// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_pkg
//  Description : Shared constants for the RV32M multiply/divide unit:
//                M-extension funct3 encodings, the MULDIV funct7 value,
//                FSM state encodings and small operand-classification
//                helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    // M-extension operation select (funct3)
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    // funct7 that marks an OP-opcode instruction as a multiply/divide
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    // Iterative unit FSM encodings
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } md_state_t;

    // Operand A is interpreted as two's complement
    function automatic logic a_is_signed(input logic [2:0] f3);
        return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
               (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    // Operand B is interpreted as two's complement (MULHSU keeps B unsigned)
    function automatic logic b_is_signed(input logic [2:0] f3);
        return (f3 == F3_MUL) || (f3 == F3_MULH) ||
               (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage
`default_nettype wire

// File: rtl/iter_divider.sv
`default_nettype none
// ============================================================================
//  Module      : iter_divider
//  Description : Restoring divide datapath. Holds the partial remainder,
//                the quotient/dividend shift register and the divisor.
//                One restoring-subtract step per 'step' cycle; after XLEN
//                steps quot/rem hold the unsigned quotient and remainder.
//  Ports       : clk, rst       - clock, async active-high reset
//                load           - capture dividend/divisor, clear remainder
//                step           - perform one divide step
//                dividend       - unsigned dividend (magnitude)
//                divisor        - unsigned divisor (magnitude)
//                quot_nxt       - quotient after the step being evaluated
//                rem_nxt        - remainder after the step being evaluated
//  Revision    : 1.0 - initial release
// ============================================================================
module iter_divider #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quot_nxt,
    output logic [XLEN-1:0] rem_nxt
);

    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_quot;
    logic [XLEN-1:0] r_dvsr;

    logic [XLEN:0]   w_shift;
    logic            w_fits;

    // Shift the next dividend bit into the partial remainder. The shifted
    // value can reach 2*divisor-1, hence the extra bit.
    assign w_shift  = {r_rem, r_quot[XLEN-1]};
    assign w_fits   = (w_shift >= {1'b0, r_dvsr});

    // When the subtraction fits, the difference is always < divisor, so
    // truncating to XLEN bits loses nothing.
    assign rem_nxt  = w_fits ? XLEN'(w_shift - {1'b0, r_dvsr}) : w_shift[XLEN-1:0];
    assign quot_nxt = {r_quot[XLEN-2:0], w_fits};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rem  <= '0;
            r_quot <= '0;
            r_dvsr <= '0;
        end else if (load) begin
            r_rem  <= '0;
            r_quot <= dividend;
            r_dvsr <= divisor;
        end else if (step) begin
            r_rem  <= rem_nxt;
            r_quot <= quot_nxt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : ex_muldiv_unit
//  Description : Iterative RV32M multiply/divide unit for the EX stage.
//                Executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU on sign-
//                stripped magnitudes (shift-add multiply, restoring divide
//                in iter_divider) and re-applies the sign at the end.
//                Holds the pipeline through stall_o and pulses done_o for
//                one cycle with the result and destination register.
//  Config      : MULDIV_FAST_MUL_EN - when defined, all multiplies use one
//                combinational 33x33 signed multiply and complete one edge
//                after acceptance. Divides are unaffected.
//  Ports       : clk, rst        - clock, async active-high reset
//                start_i         - M-extension request valid from ID/EX
//                flush_i         - kill in-flight / pending operation
//                funct3_i        - operation select
//                rs1_val_i/rs2_val_i - operands A/B
//                wr_i            - destination register
//                stall_o         - pipeline hold request (combinational)
//                done_o          - one-cycle result-valid pulse
//                result_o        - result, held until the next completion
//                wr_o            - destination register of result_o
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_muldiv_unit
    import riscv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic            flush_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_val_i,
    input  logic [XLEN-1:0] rs2_val_i,
    input  logic [4:0]      wr_i,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      wr_o
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    md_state_t         r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_funct3;
    logic [4:0]        r_wr;
    logic              r_neg;      // final result must be negated
    logic [XLEN-1:0]   r_mcand;    // |A| for the shift-add multiply
    logic [2*XLEN-1:0] r_prod;     // {partial sum, remaining multiplier bits}
    logic              r_done;
    logic [XLEN-1:0]   r_result;
    logic [4:0]        r_wr_out;

    // ------------------------------------------------------------------
    // Acceptance-side decode
    // ------------------------------------------------------------------
    logic            w_accept;
    logic            w_a_neg;
    logic            w_b_neg;
    logic            w_neg_res;
    logic [XLEN-1:0] w_mag_a;
    logic [XLEN-1:0] w_mag_b;
    logic            w_is_div_in;
    logic            w_div_zero;
    logic            w_div_ovf;
    logic            w_special;
    logic [XLEN-1:0] w_special_res;

    assign w_accept    = (r_state == ST_IDLE) && start_i && !flush_i;

    assign w_a_neg     = a_is_signed(funct3_i) && rs1_val_i[XLEN-1];
    assign w_b_neg     = b_is_signed(funct3_i) && rs2_val_i[XLEN-1];
    assign w_mag_a     = w_a_neg ? -rs1_val_i : rs1_val_i;
    assign w_mag_b     = w_b_neg ? -rs2_val_i : rs2_val_i;

    // Remainder follows the dividend's sign; products and quotients follow
    // the XOR of both operand signs.
    assign w_neg_res   = (funct3_i == F3_REM) ? w_a_neg : (w_a_neg ^ w_b_neg);

    assign w_is_div_in = funct3_i[2];
    assign w_div_zero  = (rs2_val_i == '0);
    assign w_div_ovf   = ((funct3_i == F3_DIV) || (funct3_i == F3_REM)) &&
                         (rs1_val_i == {1'b1, {(XLEN-1){1'b0}}}) &&
                         (rs2_val_i == '1);
    assign w_special   = w_is_div_in && (w_div_zero || w_div_ovf);

    // funct3[1] distinguishes REM/REMU from DIV/DIVU. For the signed
    // overflow case the quotient equals the dividend (most negative value).
    assign w_special_res = w_div_zero ? (funct3_i[1] ? rs1_val_i : '1)
                                      : (funct3_i[1] ? '0 : rs1_val_i);

    // ------------------------------------------------------------------
    // Iterative multiply step: add |A| when the current multiplier LSB is
    // set, then shift the whole product register right by one.
    // ------------------------------------------------------------------
    logic [XLEN:0]     w_sum;
    logic [2*XLEN-1:0] w_prod_nxt;
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_mul_res;

    assign w_sum      = {1'b0, r_prod[2*XLEN-1:XLEN]} +
                        (r_prod[0] ? {1'b0, r_mcand} : {(XLEN+1){1'b0}});
    assign w_prod_nxt = {w_sum, r_prod[XLEN-1:1]};
    assign w_prod_fix = r_neg ? -w_prod_nxt : w_prod_nxt;
    assign w_mul_res  = (r_funct3 == F3_MUL) ? w_prod_fix[XLEN-1:0]
                                             : w_prod_fix[2*XLEN-1:XLEN];

    // ------------------------------------------------------------------
    // Divide datapath
    // ------------------------------------------------------------------
    logic            w_div_load;
    logic            w_div_step;
    logic [XLEN-1:0] w_quot_nxt;
    logic [XLEN-1:0] w_rem_nxt;
    logic [XLEN-1:0] w_div_res;

    assign w_div_load = w_accept && w_is_div_in;
    assign w_div_step = (r_state == ST_CALC) && !flush_i && r_funct3[2];

    iter_divider #(
        .XLEN     (XLEN)
    ) u_iter_divider (
        .clk      (clk),
        .rst      (rst),
        .load     (w_div_load),
        .step     (w_div_step),
        .dividend (w_mag_a),
        .divisor  (w_mag_b),
        .quot_nxt (w_quot_nxt),
        .rem_nxt  (w_rem_nxt)
    );

    assign w_div_res = r_funct3[1] ? (r_neg ? -w_rem_nxt  : w_rem_nxt)
                                   : (r_neg ? -w_quot_nxt : w_quot_nxt);

    // Result of the final CALC step (counter == 1): the step values are
    // consumed directly so DONE lands on the same edge as the last step.
    logic [XLEN-1:0] w_final_res;
    assign w_final_res = r_funct3[2] ? w_div_res : w_mul_res;

`ifdef MULDIV_FAST_MUL_EN
    // ------------------------------------------------------------------
    // Single-cycle multiply: 33x33 signed product of the sign/zero-extended
    // operands. The size casts sign-extend so the 64-bit product is exact.
    // ------------------------------------------------------------------
    logic signed [XLEN:0]     w_fa;
    logic signed [XLEN:0]     w_fb;
    logic signed [2*XLEN-1:0] w_fast_prod;
    logic [XLEN-1:0]          w_fast_res;

    assign w_fa        = {a_is_signed(funct3_i) && rs1_val_i[XLEN-1], rs1_val_i};
    assign w_fb        = {b_is_signed(funct3_i) && rs2_val_i[XLEN-1], rs2_val_i};
    assign w_fast_prod = (2*XLEN)'(w_fa) * (2*XLEN)'(w_fb);
    assign w_fast_res  = (funct3_i == F3_MUL) ? w_fast_prod[XLEN-1:0]
                                              : w_fast_prod[2*XLEN-1:XLEN];
`endif

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_funct3 <= '0;
            r_wr     <= '0;
            r_neg    <= 1'b0;
            r_mcand  <= '0;
            r_prod   <= '0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_wr_out <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (w_accept) begin
                        r_funct3 <= funct3_i;
                        r_wr     <= wr_i;
                        r_neg    <= w_neg_res;
                        r_mcand  <= w_mag_a;
                        r_prod   <= {{XLEN{1'b0}}, w_mag_b};
                        r_cnt    <= CNT_W'(XLEN);
                        if (w_special) begin
                            r_state  <= ST_DONE;
                            r_done   <= 1'b1;
                            r_result <= w_special_res;
                            r_wr_out <= wr_i;
`ifdef MULDIV_FAST_MUL_EN
                        end else if (!w_is_div_in) begin
                            r_state  <= ST_DONE;
                            r_done   <= 1'b1;
                            r_result <= w_fast_res;
                            r_wr_out <= wr_i;
`endif
                        end else begin
                            r_state  <= ST_CALC;
                        end
                    end
                end

                ST_CALC: begin
                    if (flush_i) begin
                        // Abandon the op; visible outputs keep prior values
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                        if (!r_funct3[2]) begin
                            r_prod <= w_prod_nxt;
                        end
                        if (r_cnt == CNT_W'(1)) begin
                            r_state  <= ST_DONE;
                            r_done   <= 1'b1;
                            r_result <= w_final_res;
                            r_wr_out <= r_wr;
                        end
                    end
                end

                ST_DONE: begin
                    // Result already committed; a flush here has no effect
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign stall_o  = w_accept || (r_state == ST_CALC);
    assign done_o   = r_done;
    assign result_o = r_result;
    assign wr_o     = r_wr_out;

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ex_muldiv_unit
//  Description : Directed self-checking bench for ex_muldiv_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_muldiv_unit;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [2:0]  funct3_i = 3'b000;
    logic [31:0] rs1_val_i = '0;
    logic [31:0] rs2_val_i = '0;
    logic [4:0]  wr_i = '0;
    logic        stall_o;
    logic        done_o;
    logic [31:0] result_o;
    logic [4:0]  wr_o;

    int n_cmp = 0;
    int n_err = 0;

    ex_muldiv_unit #(.XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start_i),
        .flush_i   (flush_i),
        .funct3_i  (funct3_i),
        .rs1_val_i (rs1_val_i),
        .rs2_val_i (rs2_val_i),
        .wr_i      (wr_i),
        .stall_o   (stall_o),
        .done_o    (done_o),
        .result_o  (result_o),
        .wr_o      (wr_o)
    );

    always #5 clk = ~clk;

    // Drive one request, wait (bounded) for done_o, then one more edge.
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, output int lat, output int stalls,
                         output logic [31:0] res, output logic [4:0] rdo,
                         output logic stall_at_done, output logic done_after);
        @(negedge clk);
        funct3_i = f3; rs1_val_i = a; rs2_val_i = b; wr_i = rd; start_i = 1'b1;
        lat = 0; stalls = 0;
        forever begin
            #1;
            if (stall_o === 1'b1) stalls++;
            @(posedge clk); #1;
            lat++;
            start_i = 1'b0;
            if (done_o === 1'b1 || lat >= 100) break;
            @(negedge clk);
        end
        res = result_o; rdo = wr_o; stall_at_done = stall_o;
        @(posedge clk); #1;
        done_after = done_o;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL reset_stall got %b want 0", stall_o); end
        n_cmp++; if (done_o !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done_o); end
        n_cmp++; if (result_o !== 32'h0) begin n_err++; $display("FAIL reset_result got %h want 0", result_o); end
        n_cmp++; if (wr_o !== 5'd0) begin n_err++; $display("FAIL reset_wr got %0d want 0", wr_o); end
        rst = 1'b0;
    endtask

    task automatic test_mul();
        int lat, st; logic [31:0] r; logic [4:0] d; logic sd, da;
        issue(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, lat, st, r, d, sd, da);
        n_cmp++; if (r !== 32'hFFFF_FFEB) begin n_err++; $display("FAIL mul_result got %h want ffffffeb", r); end
        n_cmp++; if (lat !== MUL_LAT) begin n_err++; $display("FAIL mul_latency got %0d want %0d", lat, MUL_LAT); end
        n_cmp++; if (st !== MUL_LAT) begin n_err++; $display("FAIL mul_stall_cycles got %0d want %0d", st, MUL_LAT); end
        n_cmp++; if (d !== 5'd5) begin n_err++; $display("FAIL mul_wr got %0d want 5", d); end
        n_cmp++; if (sd !== 1'b0) begin n_err++; $display("FAIL mul_stall_in_done got %b want 0", sd); end
        n_cmp++; if (da !== 1'b0) begin n_err++; $display("FAIL mul_done_pulse got %b want 0", da); end
    endtask

    task automatic test_mulh();
        int lat, st; logic [31:0] r; logic [4:0] d; logic sd, da;
        issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, lat, st, r, d, sd, da);
        n_cmp++; if (r !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL mulhu_result got %h want fffffffe", r); end
        issue(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd7, lat, st, r, d, sd, da);
        n_cmp++; if (r !== 32'h4000_0000) begin n_err++; $display("FAIL mulh_result got %h want 40000000", r); end
        n_cmp++; if (lat !== MUL_LAT) begin n_err++; $display("FAIL mulh_latency got %0d want %0d", lat, MUL_LAT); end
        // -1 (signed) x 2 (unsigned) = -2 -> upper word all ones
        issue(3'b010, 32'hFFFF_FFFF, 32'd2, 5'd8, lat, st, r, d, sd, da);
        n_cmp++; if (r !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL mulhsu_result got %h want ffffffff", r); end
        // 0xFFFFFFFF unsigned x 2: MULHSU must not sign B; MULHU 0xFFFFFFFF*2 high = 1
        issue(3'b011, 32'hFFFF_FFFF, 32'd2, 5'd8, lat, st, r, d, sd, da);
        n_cmp++; if (r !== 32'h0000_0001) begin n_err++; $display("FAIL mulhu_small_result got %h want 00000001", r); end
    endtask

    task automatic test_div_special();
        int lat, st; logic [31:0] r; logic [4:0] d; logic sd, da;
        issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, lat, st, r, d, sd, da);
        n_cmp++; if (r !== 32'h8000_0000) begin n_err++; $display("FAIL div_ovf_result got %h want 80000000", r); end
        n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL div_ovf_latency got %0d want 1", lat); end
        n_cmp++; if (st !== 1) begin n_err++; $display("FAIL div_ovf_stall_cycles got %0d want 1", st); end
        n_cmp++; if (d !== 5'd10) begin n_err++; $display("FAIL div_ovf_wr got %0d want 10", d); end
        issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, lat, st, r, d, sd, da);
        n_cmp++; if (r !== 32'h0) begin n_err++; $display("FAIL rem_ovf_result got %h want 0", r); end
        issue(3'b101, 32'd100, 32'd0, 5'd12, lat, st, r, d, sd, da);
        n_cmp++; if (r !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL divu_zero_result got %h want ffffffff", r); end
        n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL divu_zero_latency got %0d want 1", lat); end
        issue(3'b111, 32'd5, 32'd0, 5'd13, lat, st, r, d, sd, da);
        n_cmp++; if (r !== 32'd5) begin n_err++; $display("FAIL remu_zero_result got %h want 5", r); end
        issue(3'b110, 32'hFFFF_FFF9, 32'd0, 5'd13, lat, st, r, d, sd, da);
        n_cmp++; if (r !== 32'hFFFF_FFF9) begin n_err++; $display("FAIL rem_zero_result got %h want fffffff9", r); end
    endtask

    task automatic test_div_normal();
        int lat, st; logic [31:0] r; logic [4:0] d; logic sd, da;
        issue(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd14, lat, st, r, d, sd, da);
        n_cmp++; if (r !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL div_neg_result got %h want fffffffd", r); end
        n_cmp++; if (lat !== DIV_LAT) begin n_err++; $display("FAIL div_latency got %0d want %0d", lat, DIV_LAT); end
        n_cmp++; if (da !== 1'b0) begin n_err++; $display("FAIL div_done_pulse got %b want 0", da); end
        issue(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd15, lat, st, r, d, sd, da);
        n_cmp++; if (r !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL rem_neg_result got %h want ffffffff", r); end
        issue(3'b101, 32'd100, 32'd7, 5'd16, lat, st, r, d, sd, da);
        n_cmp++; if (r !== 32'd14) begin n_err++; $display("FAIL divu_result got %h want 0000000e", r); end
        issue(3'b111, 32'd100, 32'd7, 5'd17, lat, st, r, d, sd, da);
        n_cmp++; if (r !== 32'd2) begin n_err++; $display("FAIL remu_result got %h want 2", r); end
        n_cmp++; if (d !== 5'd17) begin n_err++; $display("FAIL remu_wr got %0d want 17", d); end
        // 0xFFFFFFF9 unsigned / 2 = 0x7FFFFFFC
        issue(3'b101, 32'hFFFF_FFF9, 32'd2, 5'd18, lat, st, r, d, sd, da);
        n_cmp++; if (r !== 32'h7FFF_FFFC) begin n_err++; $display("FAIL divu_big_result got %h want 7ffffffc", r); end
    endtask

    task automatic test_flush();
        int lat, st, seen; logic [31:0] r; logic [4:0] d; logic sd, da;
        // Known prior result: REMU 100 % 7 = 2 to rd 17
        issue(3'b111, 32'd100, 32'd7, 5'd17, lat, st, r, d, sd, da);
        @(negedge clk);
        funct3_i = 3'b101; rs1_val_i = 32'd100; rs2_val_i = 32'd7; wr_i = 5'd20; start_i = 1'b1;
        @(posedge clk); #1; start_i = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk); flush_i = 1'b1;
        @(posedge clk); #1; flush_i = 1'b0;
        n_cmp++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL flush_calc_stall got %b want 0", stall_o); end
        n_cmp++; if (result_o !== 32'd2) begin n_err++; $display("FAIL flush_calc_result_kept got %h want 2", result_o); end
        n_cmp++; if (wr_o !== 5'd17) begin n_err++; $display("FAIL flush_calc_wr_kept got %0d want 17", wr_o); end
        seen = 0;
        repeat (40) begin @(posedge clk); #1; if (done_o === 1'b1) seen++; end
        n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL flush_calc_no_done got %0d pulses want 0", seen); end
        // Flush in IDLE wins over start
        @(negedge clk);
        funct3_i = 3'b101; rs1_val_i = 32'd100; rs2_val_i = 32'd0; wr_i = 5'd21;
        start_i = 1'b1; flush_i = 1'b1;
        #1;
        n_cmp++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL flush_idle_stall got %b want 0", stall_o); end
        @(posedge clk); #1; start_i = 1'b0; flush_i = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (done_o !== 1'b0) begin n_err++; $display("FAIL flush_idle_done got %b want 0", done_o); end
        // New request accepted after a flush
        issue(3'b101, 32'd100, 32'd0, 5'd22, lat, st, r, d, sd, da);
        n_cmp++; if (r !== 32'hFFFF_FFFF || lat !== 1) begin n_err++; $display("FAIL flush_restart got %h lat %0d want ffffffff lat 1", r, lat); end
        // Flush during DONE: pulse still delivered
        @(negedge clk);
        funct3_i = 3'b111; rs1_val_i = 32'd9; rs2_val_i = 32'd0; wr_i = 5'd3; start_i = 1'b1;
        @(posedge clk); #1; start_i = 1'b0; flush_i = 1'b1;
        n_cmp++; if (done_o !== 1'b1 || result_o !== 32'd9) begin n_err++; $display("FAIL flush_done_pulse got done %b result %h want 1 9", done_o, result_o); end
        @(posedge clk); #1; flush_i = 1'b0;
        n_cmp++; if (done_o !== 1'b0) begin n_err++; $display("FAIL flush_done_end got %b want 0", done_o); end
    endtask

    task automatic test_back_to_back();
        int lat, lat2;
        @(negedge clk);
        funct3_i = 3'b101; rs1_val_i = 32'd100; rs2_val_i = 32'd7; wr_i = 5'd4; start_i = 1'b1;
        @(posedge clk); #1; lat = 1;
        // start_i stays high with new operands: must be ignored outside IDLE
        funct3_i = 3'b000; rs1_val_i = 32'd3; rs2_val_i = 32'd3; wr_i = 5'd6;
        while (done_o !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
        n_cmp++; if (lat !== DIV_LAT || result_o !== 32'd14 || wr_o !== 5'd4) begin
            n_err++; $display("FAIL b2b_first got lat %0d result %h wr %0d want %0d 0000000e 4", lat, result_o, wr_o, DIV_LAT);
        end
        lat2 = 0;
        do begin @(posedge clk); #1; lat2++; end while (done_o !== 1'b1 && lat2 < 100);
        start_i = 1'b0;
        n_cmp++; if (lat2 !== MUL_LAT + 1 || result_o !== 32'd9 || wr_o !== 5'd6) begin
            n_err++; $display("FAIL b2b_second got lat %0d result %h wr %0d want %0d 9 6", lat2, result_o, wr_o, MUL_LAT + 1);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_async_reset();
        int lat, st; logic [31:0] r; logic [4:0] d; logic sd, da;
        @(negedge clk);
        funct3_i = 3'b000; rs1_val_i = 32'd7; rs2_val_i = 32'hFFFF_FFFD; wr_i = 5'd9; start_i = 1'b1;
        @(posedge clk); #1; start_i = 1'b0;
        repeat (5) @(posedge clk);
        #3; rst = 1'b1; #1;
        n_cmp++; if (stall_o !== 1'b0 || done_o !== 1'b0) begin n_err++; $display("FAIL arst_ctrl got stall %b done %b want 0 0", stall_o, done_o); end
        n_cmp++; if (result_o !== 32'h0 || wr_o !== 5'd0) begin n_err++; $display("FAIL arst_data got %h wr %0d want 0 0", result_o, wr_o); end
        @(negedge clk); rst = 1'b0;
        issue(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd9, lat, st, r, d, sd, da);
        n_cmp++; if (r !== 32'hFFFF_FFEB || lat !== MUL_LAT) begin n_err++; $display("FAIL arst_rerun got %h lat %0d want ffffffeb lat %0d", r, lat, MUL_LAT); end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mulh();
        test_div_special();
        test_div_normal();
        test_flush();
        test_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
